// File: rtl/plru_replacement_unit_pkg.sv
// plru_pkg: shared defaults, flush FSM states and tree PLRU helper functions
package plru_pkg;
  localparam int ASSOC_DEF = 4;
  localparam int NUM_SETS_DEF = 256;
  localparam int MAX_ASSOC = 16;
  localparam int MAX_W = 4;
  typedef enum logic {IDLE, SWEEP} flush_state_e;
  function automatic logic [MAX_W-1:0] tree_victim(input logic [MAX_ASSOC-2:0] s, input int assoc);
    int n;
    n = 0;
    for (int l = 0; l < MAX_W; l++)
      if ((2 << l) <= assoc) n = 2 * n + 1 + int'(s[4'(n)]);
    return 4'(n - (assoc - 1));
  endfunction
  function automatic logic [MAX_ASSOC-2:0] tree_update(input logic [MAX_ASSOC-2:0] s, input logic [MAX_W-1:0] way, input int assoc);
    logic [MAX_ASSOC-2:0] r;
    int n;
    r = s;
    n = int'(way) + assoc - 1;
    for (int l = 0; l < MAX_W; l++)
      if (n > 0) begin
        r[4'((n - 1) / 2)] = n[0];
        n = (n - 1) / 2;
      end
    return r;
  endfunction
  function automatic logic [MAX_W:0] first_invalid(input logic [MAX_ASSOC-1:0] mask, input int assoc);
    logic [MAX_W:0] r;
    r = '0;
    for (int i = MAX_ASSOC - 1; i >= 0; i--)
      if (i < assoc && !mask[4'(i)]) r = {1'b1, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/plru_replacement_unit_if.sv
// plru_replacement_unit_if: lookup, access and flush signals between cache and PLRU unit
interface plru_replacement_unit_if
  import plru_pkg::*;
#(
  parameter int ASSOC = ASSOC_DEF,
  parameter int NUM_SETS = NUM_SETS_DEF
) ();
  localparam int WAY_W = $clog2(ASSOC);
  localparam int IDX_W = $clog2(NUM_SETS);
  logic [IDX_W-1:0] lookup_index;
  logic [ASSOC-1:0] valid_mask;
  logic [WAY_W-1:0] victim_way;
  logic access_valid;
  logic [IDX_W-1:0] access_index;
  logic [WAY_W-1:0] access_way;
  logic access_ready;
  logic flush_req;
  logic flush_busy;
  logic flush_done;
  modport master (
    output lookup_index, valid_mask, access_valid, access_index, access_way, flush_req,
    input victim_way, access_ready, flush_busy, flush_done
  );
  modport slave (
    input lookup_index, valid_mask, access_valid, access_index, access_way, flush_req,
    output victim_way, access_ready, flush_busy, flush_done
  );
endinterface

// File: rtl/plru_replacement_unit_tree_logic.sv
// plru_tree_logic: combinational victim pick (invalid ways first) and path update for one set
module plru_tree_logic
  import plru_pkg::*;
#(
  parameter int ASSOC = ASSOC_DEF,
  localparam int WAY_W = $clog2(ASSOC)
) (
  input  logic [ASSOC-2:0] state,
  input  logic [ASSOC-1:0] valid_mask,
  input  logic [WAY_W-1:0] way,
  output logic [WAY_W-1:0] victim,
  output logic [ASSOC-2:0] next_state
);
  logic [MAX_ASSOC-2:0] s_ext;
  logic [MAX_W:0] inv;
  // widen to the package's maximum tree size, then narrow results back to ASSOC
  always_comb begin
    s_ext = (MAX_ASSOC-1)'(state);
    inv = first_invalid(MAX_ASSOC'(valid_mask), ASSOC);
    victim = inv[MAX_W] ? WAY_W'(inv[MAX_W-1:0]) : WAY_W'(tree_victim(s_ext, ASSOC));
    next_state = (ASSOC-1)'(tree_update(s_ext, MAX_W'(way), ASSOC));
  end
endmodule

// File: rtl/plru_replacement_unit.sv
// plru_replacement_unit: per-set tree PLRU state with victim lookup, access update and flush sweep
module plru_replacement_unit
  import plru_pkg::*;
#(
  parameter int ASSOC = ASSOC_DEF,
  parameter int NUM_SETS = NUM_SETS_DEF
) (
  input logic clk,
  input logic rst_n,
  plru_replacement_unit_if.slave bus
);
  localparam int WAY_W = $clog2(ASSOC);
  localparam int IDX_W = $clog2(NUM_SETS);
  logic [ASSOC-2:0] tree [NUM_SETS];
  flush_state_e fsm;
  logic [IDX_W-1:0] cnt;
  logic done_q;
  logic [ASSOC-2:0] acc_next;
  logic [ASSOC-2:0] unused_lk_next;
  logic [WAY_W-1:0] unused_acc_victim;
  plru_tree_logic #(.ASSOC(ASSOC)) u_lookup (
    .state(tree[bus.lookup_index]),
    .valid_mask(bus.valid_mask),
    .way('0),
    .victim(bus.victim_way),
    .next_state(unused_lk_next)
  );
  plru_tree_logic #(.ASSOC(ASSOC)) u_access (
    .state(tree[bus.access_index]),
    .valid_mask('1),
    .way(bus.access_way),
    .victim(unused_acc_victim),
    .next_state(acc_next)
  );
  assign bus.access_ready = fsm == IDLE;
  assign bus.flush_busy = fsm == SWEEP;
  assign bus.flush_done = done_q;
  // flush sequencer: done pulses while the last set is being swept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
    end else if (fsm == IDLE) begin
      done_q <= 1'b0;
      if (bus.flush_req) begin
        fsm <= SWEEP;
        cnt <= '0;
      end
    end else if (cnt == IDX_W'(NUM_SETS - 1)) begin
      fsm <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      done_q <= cnt == IDX_W'(NUM_SETS - 2);
    end
  // tree state: sweep clears one set per cycle, otherwise accepted accesses update their path
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) tree[i] <= '0;
    end else if (fsm == SWEEP) begin
      tree[cnt] <= '0;
    end else if (bus.access_valid) begin
      tree[bus.access_index] <= acc_next;
    end
endmodule
